// File: rtl/score_display_pkg.sv
// score_display_pkg
// Shared definitions for the score display slice:
//   - position codes (WR..WL, ERROR) as seen on the position output
//   - LED pattern constants for the win and error displays
//   - FSM state enum for score_display
//   - helpers mapping a position code to its LED pattern
package score_display_pkg;

  localparam logic [3:0] POS_ERROR = 4'd0;
  localparam logic [3:0] POS_WR    = 4'd1;
  localparam logic [3:0] POS_R3    = 4'd2;
  localparam logic [3:0] POS_R2    = 4'd3;
  localparam logic [3:0] POS_R1    = 4'd4;
  localparam logic [3:0] POS_N     = 4'd5;
  localparam logic [3:0] POS_L1    = 4'd6;
  localparam logic [3:0] POS_L2    = 4'd7;
  localparam logic [3:0] POS_L3    = 4'd8;
  localparam logic [3:0] POS_WL    = 4'd9;

  localparam logic [6:0] LED_WL    = 7'b1110000;
  localparam logic [6:0] LED_WR    = 7'b0000111;
  localparam logic [6:0] LED_ERROR = 7'b1010101;
  localparam logic [6:0] LED_N     = 7'b0001000;
  localparam logic [6:0] LED_OFF   = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLIDE = 2'd1,
    ST_WIN   = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  function automatic logic is_win(input logic [3:0] code);
    return (code == POS_WR) || (code == POS_WL);
  endfunction

  function automatic logic is_play(input logic [3:0] code);
    return (code >= POS_R3) && (code <= POS_L3);
  endfunction

  // Playfield codes 2..8 map onto bits 0..6 (R3 is bit 0, L3 is bit 6).
  function automatic logic [6:0] pos_leds(input logic [3:0] code);
    logic [6:0] l;
    l = LED_OFF;
    if (code == POS_WR)      l = LED_WR;
    else if (code == POS_WL) l = LED_WL;
    else if (is_play(code))  l = 7'b0000001 << (code - POS_R3);
    return l;
  endfunction

endpackage

// File: rtl/score_display_decode.sv
// score_decode
// Combinational decode of the 7-bit scorer word [L3 L2 L1 N R1 R2 R3]
// into a 4-bit position code. Anything that is not a legal single
// position or a win word decodes to POS_ERROR.
//   score : in  7  scorer word
//   code  : out 4  position code (0 = error)
module score_decode (
  input  logic [6:0] score,
  output logic [3:0] code
);
  import score_display_pkg::*;

  always_comb begin
    code = POS_ERROR;
    case (score)
      7'b1000000: code = POS_L3;
      7'b0100000: code = POS_L2;
      7'b0010000: code = POS_L1;
      7'b0001000: code = POS_N;
      7'b0000100: code = POS_R1;
      7'b0000010: code = POS_R2;
      7'b0000001: code = POS_R3;
      LED_WL:     code = POS_WL;
      LED_WR:     code = POS_WR;
      default:    code = POS_ERROR;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// score_display
// Drives a 7-LED score bar from the registered scorer word. Position
// changes slide one LED per STEP_CYCLES clocks, a win blinks its three
// LEDs with a BLINK_CYCLES half-period, and illegal words show a fixed
// error pattern.
//   clk       : in   1  clock
//   rst       : in   1  asynchronous reset, active low
//   score     : in   7  scorer word
//   leds      : out  7  LED pattern
//   position  : out  4  displayed position code (0 in error)
//   moving    : out  1  sliding
//   step      : out  1  one-cycle pulse per position change
//   game_over : out  1  win display active
//   code_err  : out  1  error display active
module score_display #(
  parameter int unsigned STEP_CYCLES  = 4,
  parameter int unsigned BLINK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] score,
  output logic [6:0] leds,
  output logic [3:0] position,
  output logic       moving,
  output logic       step,
  output logic       game_over,
  output logic       code_err
);
  import score_display_pkg::*;

  localparam logic [7:0] STEP_LAST  = 8'(STEP_CYCLES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_CYCLES - 1);

  logic [6:0] score_q;
  logic [3:0] dec;
  state_e     state_q, state_d;
  logic [3:0] cur_pos_q, cur_pos_d, tgt_pos_q, tgt_pos_d;
  logic [7:0] step_cnt_q, step_cnt_d, blink_cnt_q, blink_cnt_d;
  logic       blink_on_q, blink_on_d;
  logic       step_q, step_d;
  logic       moving_q, game_over_q, code_err_q;

  score_decode u_decode (
    .score (score_q),
    .code  (dec)
  );

  always_comb begin
    state_d     = state_q;
    cur_pos_d   = cur_pos_q;
    tgt_pos_d   = tgt_pos_q;
    step_cnt_d  = step_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    step_d      = 1'b0;

    // WIN and ERR are checked before any slide bookkeeping so they
    // override a step that would otherwise land this cycle.
    case (state_q)
      ST_IDLE, ST_SLIDE: begin
        if (dec == POS_ERROR) begin
          state_d = ST_ERR;
        end else if (is_win(dec)) begin
          state_d     = ST_WIN;
          cur_pos_d   = dec;
          blink_on_d  = 1'b1;
          blink_cnt_d = '0;
          step_d      = 1'b1;
        end else if (state_q == ST_IDLE) begin
          if (dec != cur_pos_q) begin
            state_d    = ST_SLIDE;
            tgt_pos_d  = dec;
            step_cnt_d = '0;
          end
        end else begin
          // Retarget every cycle; the step timer keeps running.
          tgt_pos_d = dec;
          if (cur_pos_q == tgt_pos_q) begin
            state_d    = ST_IDLE;
            step_cnt_d = '0;
          end else if (step_cnt_q == STEP_LAST) begin
            step_cnt_d = '0;
            cur_pos_d  = (tgt_pos_q > cur_pos_q) ? cur_pos_q + 4'd1
                                                 : cur_pos_q - 4'd1;
            step_d     = 1'b1;
          end else begin
            step_cnt_d = step_cnt_q + 8'd1;
          end
        end
      end
      ST_WIN: begin
        if (dec == POS_N) begin
          state_d    = ST_IDLE;
          cur_pos_d  = POS_N;
          tgt_pos_d  = POS_N;
          blink_on_d = 1'b0;
        end else if (dec == POS_ERROR) begin
          state_d = ST_ERR;
        end else if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          blink_on_d  = ~blink_on_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 8'd1;
        end
      end
      ST_ERR: begin
        if (is_win(dec)) begin
          state_d     = ST_WIN;
          cur_pos_d   = dec;
          blink_on_d  = 1'b1;
          blink_cnt_d = '0;
          step_d      = 1'b1;
        end else if (is_play(dec)) begin
          state_d   = ST_IDLE;
          cur_pos_d = dec;
          tgt_pos_d = dec;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_q     <= LED_N;
      state_q     <= ST_IDLE;
      cur_pos_q   <= POS_N;
      tgt_pos_q   <= POS_N;
      step_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b0;
      step_q      <= 1'b0;
      moving_q    <= 1'b0;
      game_over_q <= 1'b0;
      code_err_q  <= 1'b0;
    end else begin
      score_q     <= score;
      state_q     <= state_d;
      cur_pos_q   <= cur_pos_d;
      tgt_pos_q   <= tgt_pos_d;
      step_cnt_q  <= step_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      step_q      <= step_d;
      moving_q    <= (state_d == ST_SLIDE);
      game_over_q <= (state_d == ST_WIN);
      code_err_q  <= (state_d == ST_ERR);
    end
  end

  always_comb begin
    leds     = pos_leds(cur_pos_q);
    position = cur_pos_q;
    case (state_q)
      ST_WIN: leds = blink_on_q ? pos_leds(cur_pos_q) : LED_OFF;
      ST_ERR: begin
        leds     = LED_ERROR;
        position = POS_ERROR;
      end
      default: ;
    endcase
  end

  assign moving    = moving_q;
  assign step      = step_q;
  assign game_over = game_over_q;
  assign code_err  = code_err_q;

endmodule
